// File: rtl/ram_arbiter_2m_if.sv
// One Avalon-MM requester port of ram_arbiter_2m.
// master = requester (interconnect) side, slave = arbiter side.
interface ram_arbiter_2m_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   // Handshake: a request (read or write high) is accepted on the rising edge where
   // waitrequest is low; while waitrequest is high the requester holds every request
   // field stable. readdatavalid qualifies readdata for exactly one cycle per read.
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/ram_arbiter_2m.sv
// Round-robin, grant-hold-limited arbiter sharing one single-port RAM between two Avalon-MM masters.
// Optional out-of-range address check: define RAM_ARB_RANGE_CHECK_EN.
module ram_arbiter_2m #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 10240,
   parameter int READ_LATENCY = 1,
   parameter int HOLD_MAX     = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   ram_arbiter_2m_if.slave     m0,
   ram_arbiter_2m_if.slave     m1,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
`ifdef RAM_ARB_RANGE_CHECK_EN
   ,
   output logic                range_err
`endif
);

   localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

   logic                    w_req0, w_req1, w_any, w_acc;
   logic                    w_keep, w_win, w_wr, w_rd, w_rd_acc, w_oob;
   logic [ADDR_W-1:0]       w_addr;
   logic                    w_tail_vld, w_tail_own;
   logic [DATA_W-1:0]       w_tail_data;

   logic                    r_last_grant;
   logic [3:0]              r_hold_cnt;
   logic [READ_LATENCY-1:0] r_pipe_vld, r_pipe_own;
   logic                    r_rdv0, r_rdv1;
   logic [DATA_W-1:0]       r_rdata0, r_rdata1;

   assign w_req0 = m0.read | m0.write;
   assign w_req1 = m1.read | m1.write;
   assign w_any  = w_req0 | w_req1;
   assign w_acc  = w_any & reset_n;

   // hold_cnt == 0 means no run in progress (after reset or an idle cycle), so the
   // next contention goes to ~last_grant; this is what gives m0 the first contention.
   assign w_keep = (r_hold_cnt != 4'd0) && (r_hold_cnt < HOLD_MAX_C);
   assign w_win  = (w_req0 & w_req1) ? (w_keep ? r_last_grant : ~r_last_grant) : w_req1;

   assign w_addr   = w_win ? m1.address : m0.address;
   assign w_wr     = w_win ? m1.write   : m0.write;
   assign w_rd     = w_win ? m1.read    : m0.read;
   assign w_rd_acc = w_acc & w_rd & ~w_wr;

`ifdef RAM_ARB_RANGE_CHECK_EN
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   assign w_oob = ({1'b0, w_addr} >= DEPTH_C);
`else
   assign w_oob = 1'b0;
`endif

   assign ram_address    = w_addr;
   assign ram_byteenable = w_win ? m1.byteenable : m0.byteenable;
   assign ram_writedata  = w_win ? m1.writedata  : m0.writedata;
   assign ram_write      = w_acc & w_wr & ~w_oob;
   assign ram_chipselect = w_acc & ~w_oob;
   assign ram_clken      = 1'b1;

   assign m0.waitrequest   = ~reset_n | (w_any & w_win);
   assign m1.waitrequest   = ~reset_n | (w_any & ~w_win);
   assign m0.readdata      = r_rdata0;
   assign m0.readdatavalid = r_rdv0;
   assign m1.readdata      = r_rdata1;
   assign m1.readdatavalid = r_rdv1;

   assign w_tail_vld = r_pipe_vld[READ_LATENCY-1];
   assign w_tail_own = r_pipe_own[READ_LATENCY-1];

`ifdef RAM_ARB_RANGE_CHECK_EN
   logic [READ_LATENCY-1:0] r_pipe_oob;
   logic                    r_range_err;

   assign w_tail_data = r_pipe_oob[READ_LATENCY-1] ? DATA_W'(32'hDEADBEEF) : ram_readdata;
   assign range_err   = r_range_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe_oob  <= '0;
         r_range_err <= 1'b0;
      end else begin
         r_pipe_oob <= (r_pipe_oob << 1) | READ_LATENCY'(w_rd_acc & w_oob);
         if (w_acc & w_oob)
            r_range_err <= 1'b1;
      end
   end
`else
   assign w_tail_data = ram_readdata;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_hold_cnt   <= 4'd0;
         r_pipe_vld   <= '0;
         r_pipe_own   <= '0;
         r_rdv0       <= 1'b0;
         r_rdv1       <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         if (w_any) begin
            if (w_win == r_last_grant) begin
               if (r_hold_cnt != HOLD_MAX_C)
                  r_hold_cnt <= r_hold_cnt + 4'd1;
            end else begin
               r_last_grant <= w_win;
               r_hold_cnt   <= 4'd1;
            end
         end else begin
            r_hold_cnt <= 4'd0;
         end

         // {valid, owner} travel alongside the RAM read so data meets its owner at the tail.
         r_pipe_vld <= (r_pipe_vld << 1) | READ_LATENCY'(w_rd_acc);
         r_pipe_own <= (r_pipe_own << 1) | READ_LATENCY'(w_win);

         r_rdv0 <= w_tail_vld & ~w_tail_own;
         r_rdv1 <= w_tail_vld &  w_tail_own;
         if (w_tail_vld & ~w_tail_own)
            r_rdata0 <= w_tail_data;
         if (w_tail_vld & w_tail_own)
            r_rdata1 <= w_tail_data;
      end
   end

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// Directed bench for ram_arbiter_2m: behavioural RAM, memory model and per-master
// expected-response queues tagged with the cycle each response is due.
`timescale 1ns/1ps
module tb_ram_arbiter_2m;
   localparam int RL = 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_2m_if bus0 ();
   ram_arbiter_2m_if bus1 ();

   logic [13:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata = 32'h0;
`ifdef RAM_ARB_RANGE_CHECK_EN
   logic        range_err;
`endif

   ram_arbiter_2m dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .m0             (bus0),
      .m1             (bus1),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata)
`ifdef RAM_ARB_RANGE_CHECK_EN
      ,
      .range_err      (range_err)
`endif
   );

   // Behavioural single-port RAM, 1-cycle read latency.
   logic [31:0] ram_mem [0:16383] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= ram_mem[ram_address];
         end
      end
   end

   logic [31:0] model_mem [0:16383] = '{default: 32'h0};
   logic [47:0] exp_q0[$];
   logic [47:0] exp_q1[$];
   int          grant_log[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [47:0] mon_e0, mon_e1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every readdatavalid must match the oldest expectation for that master.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus0.readdatavalid) begin
            if (exp_q0.size() == 0) check("m0_unexpected_rdv", 48'(bus0.readdatavalid), 48'h0);
            else begin
               mon_e0 = exp_q0.pop_front();
               check("m0_rdata", 48'(bus0.readdata), 48'(mon_e0[31:0]));
               check("m0_rdv_cycle", 48'(16'(cyc)), 48'(mon_e0[47:32]));
            end
         end
         if (bus1.readdatavalid) begin
            if (exp_q1.size() == 0) check("m1_unexpected_rdv", 48'(bus1.readdatavalid), 48'h0);
            else begin
               mon_e1 = exp_q1.pop_front();
               check("m1_rdata", 48'(bus1.readdata), 48'(mon_e1[31:0]));
               check("m1_rdv_cycle", 48'(16'(cyc)), 48'(mon_e1[47:32]));
            end
         end
      end
   end

   task automatic clear_port(input int p);
      if (p == 0) begin bus0.read = 1'b0; bus0.write = 1'b0; end
      else        begin bus1.read = 1'b0; bus1.write = 1'b0; end
   endtask

   // Drive one request, hold it until accepted, record grant and expected response.
   task automatic issue(input int p, input logic rd, input logic wr, input logic [13:0] a,
                        input logic [3:0] be, input logic [31:0] d, input bit exp_resp,
                        output int waits);
      int   n;
      logic wq;
      logic oob;
      logic [31:0] ev;
      if (p == 0) begin
         bus0.address = a; bus0.byteenable = be; bus0.writedata = d; bus0.read = rd; bus0.write = wr;
      end else begin
         bus1.address = a; bus1.byteenable = be; bus1.writedata = d; bus1.read = rd; bus1.write = wr;
      end
      n = 0;
      do begin
         @(negedge clk);
         wq = (p == 0) ? bus0.waitrequest : bus1.waitrequest;
         n++;
      end while (wq !== 1'b0 && n < 64);
      waits = n - 1;
`ifdef RAM_ARB_RANGE_CHECK_EN
      oob = (a >= 14'd10240);
`else
      oob = 1'b0;
`endif
      if (wq !== 1'b0) check("accept_timeout", 48'(wq), 48'h0);
      else begin
         grant_log.push_back(p);
         if (wr) begin
            if (!oob)
               for (int b = 0; b < 4; b++)
                  if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
         end else if (rd && exp_resp) begin
            ev = oob ? 32'hDEADBEEF : model_mem[a];
            if (p == 0) exp_q0.push_back({16'(cyc + 1 + RL), ev});
            else        exp_q1.push_back({16'(cyc + 1 + RL), ev});
         end
      end
      @(posedge clk);
      #1;
      clear_port(p);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clear_port(0);
      clear_port(1);
      @(negedge clk);
      check("rst_wait0", 48'(bus0.waitrequest), 48'h1);
      check("rst_wait1", 48'(bus1.waitrequest), 48'h1);
      check("rst_cs", 48'(ram_chipselect), 48'h0);
      check("rst_rdv0", 48'(bus0.readdatavalid), 48'h0);
      check("rst_rdv1", 48'(bus1.readdatavalid), 48'h0);
      check("rst_rdata0", 48'(bus0.readdata), 48'h0);
      check("rst_rdata1", 48'(bus1.readdata), 48'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, w1;
      bus0.address = '0; bus0.byteenable = '0; bus0.writedata = '0; bus0.read = 1'b0; bus0.write = 1'b0;
      bus1.address = '0; bus1.byteenable = '0; bus1.writedata = '0; bus1.read = 1'b0; bus1.write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      apply_reset();

      // Idle after reset: both ports ready, RAM deselected, clock enable tied high.
      @(negedge clk);
      check("idle_wait0", 48'(bus0.waitrequest), 48'h0);
      check("idle_wait1", 48'(bus1.waitrequest), 48'h0);
      check("idle_cs", 48'(ram_chipselect), 48'h0);
      check("clken", 48'(ram_clken), 48'h1);
      @(posedge clk);
      #1;

      // m0 write then read-back of address 5.
      issue(0, 1'b0, 1'b1, 14'd5, 4'hF, 32'h11223344, 1'b0, w0);
      issue(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b1, w0);
      repeat (3) @(negedge clk);
      check("t_rw_m0_data", 48'(bus0.readdata), 48'h11223344);
      check("t_rw_drained", 48'(exp_q0.size()), 48'h0);
      @(posedge clk); #1;

      // m1 partial write merges one byte into a zeroed word.
      issue(1, 1'b0, 1'b1, 14'd7, 4'hF, 32'h0, 1'b0, w1);
      issue(1, 1'b0, 1'b1, 14'd7, 4'b0010, 32'hAABBCCDD, 1'b0, w1);
      issue(1, 1'b1, 1'b0, 14'd7, 4'hF, 32'h0, 1'b1, w1);
      repeat (3) @(negedge clk);
      check("t_be_merge", 48'(bus1.readdata), 48'h0000CC00);
      @(posedge clk); #1;

      // Simultaneous m0 write / m1 read of one address right after reset.
      apply_reset();
      grant_log.delete();
      fork
         issue(0, 1'b0, 1'b1, 14'd20, 4'hF, 32'h55AA1234, 1'b0, w0);
         issue(1, 1'b1, 1'b0, 14'd20, 4'hF, 32'h0, 1'b1, w1);
      join
      repeat (3) @(negedge clk);
      check("t_sim_first", 48'(grant_log[0]), 48'h0);
      check("t_sim_second", 48'(grant_log[1]), 48'h1);
      check("t_sim_m1_wait", 48'(w1), 48'h1);
      check("t_sim_m1_data", 48'(bus1.readdata), 48'h55AA1234);
      @(posedge clk); #1;

      // Distinct contents, then both masters stream reads: grants alternate in runs of 4.
      for (int i = 0; i < 12; i++) issue(0, 1'b0, 1'b1, 14'(100 + i), 4'hF, 32'hA0000000 | i, 1'b0, w0);
      for (int i = 0; i < 12; i++) issue(1, 1'b0, 1'b1, 14'(200 + i), 4'hF, 32'hB0000000 | i, 1'b0, w1);
      apply_reset();
      grant_log.delete();
      fork
         begin
            for (int i = 0; i < 12; i++) issue(0, 1'b1, 1'b0, 14'(100 + i), 4'hF, 32'h0, 1'b1, w0);
         end
         begin
            for (int j = 0; j < 12; j++) issue(1, 1'b1, 1'b0, 14'(200 + j), 4'hF, 32'h0, 1'b1, w1);
         end
      join
      repeat (4) @(negedge clk);
      check("t_rr_count", 48'(grant_log.size()), 48'd24);
      for (int k = 0; k < grant_log.size() && k < 24; k++)
         check($sformatf("t_rr_grant%0d", k), 48'(grant_log[k]), 48'((k / 4) % 2));
      check("t_rr_drained0", 48'(exp_q0.size()), 48'h0);
      check("t_rr_drained1", 48'(exp_q1.size()), 48'h0);
      @(posedge clk); #1;

      // Reset with a read in flight: the response must never appear.
      issue(0, 1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b0, w0);
      reset_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("t_mid_rst_rdv0", 48'(bus0.readdatavalid), 48'h0);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("t_mid_post_rdv0", 48'(bus0.readdatavalid), 48'h0);
         check("t_mid_post_rdv1", 48'(bus1.readdatavalid), 48'h0);
      end
      @(posedge clk); #1;
      grant_log.delete();
      fork
         issue(0, 1'b0, 1'b1, 14'd30, 4'hF, 32'h1, 1'b0, w0);
         issue(1, 1'b0, 1'b1, 14'd31, 4'hF, 32'h2, 1'b0, w1);
      join
      check("t_mid_first_grant", 48'(grant_log[0]), 48'h0);

`ifdef RAM_ARB_RANGE_CHECK_EN
      // Out-of-range read returns the marker word; out-of-range write never reaches the RAM.
      check("t_oob_err_clear", 48'(range_err), 48'h0);
      issue(0, 1'b1, 1'b0, 14'd10240, 4'hF, 32'h0, 1'b1, w0);
      repeat (3) @(negedge clk);
      check("t_oob_rdata", 48'(bus0.readdata), 48'hDEADBEEF);
      check("t_oob_err_set", 48'(range_err), 48'h1);
      @(posedge clk); #1;
      bus0.address = 14'd12000; bus0.byteenable = 4'hF; bus0.writedata = 32'h12345678; bus0.write = 1'b1;
      @(negedge clk);
      check("t_oob_wr_accept", 48'(bus0.waitrequest), 48'h0);
      check("t_oob_wr_cs", 48'(ram_chipselect), 48'h0);
      @(posedge clk); #1;
      clear_port(0);
`endif

      repeat (4) @(negedge clk);
      check("final_drained0", 48'(exp_q0.size()), 48'h0);
      check("final_drained1", 48'(exp_q1.size()), 48'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
